// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants for the multi-ported register file.
//   DEF_DATA_W : default register width
//   DEF_ADDR_W : default register address width
//   ZERO_REG   : address of the hard-wired zero register
package regfile_mp_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/regfile_mp_wrsel.sv
// regfile_mp_wrsel: combinational winner selection across write ports for one
// target address. Used per register on the write path and per read port on
// the bypass path.
//   addr     in  : address being resolved
//   wr_en    in  : per-port write strobes
//   wr_addr  in  : packed write addresses
//   wr_data  in  : packed write data
//   hit      out : at least one enabled port writes addr (never for addr 0)
//   data     out : data of the highest-index port writing addr
//   conflict out: two or more enabled ports write addr (never for addr 0)
module regfile_mp_wrsel
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WR_PORTS = 2
) (
  input  logic [ADDR_W-1:0]          addr,
  input  logic [WR_PORTS-1:0]        wr_en,
  input  logic [WR_PORTS*ADDR_W-1:0] wr_addr,
  input  logic [WR_PORTS*DATA_W-1:0] wr_data,
  output logic                       hit,
  output logic [DATA_W-1:0]          data,
  output logic                       conflict
);

  // Ascending scan: a later (higher-index) match overwrites data, so the
  // highest-index port wins. A match seen after an earlier one is a conflict.
  always_comb begin
    hit      = 1'b0;
    data     = '0;
    conflict = 1'b0;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == addr) &&
          (addr != ADDR_W'(ZERO_REG))) begin
        conflict = conflict | hit;
        hit      = 1'b1;
        data     = wr_data[p*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported register file with busy scoreboard.
//   clk, rst (async, active-high), en (global enable, low freezes all state)
//   wr_en/wr_addr/wr_data : WR_PORTS packed write ports
//   rd_addr               : RD_PORTS packed read addresses
//   rd_data/rd_busy       : registered read data and busy flag per read port
//   busy_set/busy_addr    : mark a register as having an in-flight producer
//   wr_conflict           : registered, two or more ports wrote one non-zero address
// Optional build macro: REGFILE_MP_BYPASS_EN enables same-cycle write-to-read
// forwarding; without it reads return the pre-write contents.
// There is no handshake: every port is a plain per-cycle strobe qualified by en.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WR_PORTS-1:0]        wr_en,
  input  logic [WR_PORTS*ADDR_W-1:0] wr_addr,
  input  logic [WR_PORTS*DATA_W-1:0] wr_data,
  input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  output logic [RD_PORTS-1:0]        rd_busy,
  input  logic                       busy_set,
  input  logic [ADDR_W-1:0]          busy_addr,
  output logic                       wr_conflict
);

  localparam int SIZE = 2 ** ADDR_W;

  logic [DATA_W-1:0]          regs [SIZE];
  logic [SIZE-1:0]            busy;
  logic [SIZE-1:0]            busy_next;

  logic [SIZE-1:0]            w_hit;
  logic [SIZE-1:0]            w_conf;
  logic [DATA_W-1:0]          w_data [SIZE];

  logic [RD_PORTS*DATA_W-1:0] rd_data_next;
  logic [RD_PORTS-1:0]        rd_busy_next;

  // Per-register winner. Address 0 never reports a hit, so regs[0] stays 0.
  for (genvar a = 0; a < SIZE; a++) begin : g_wsel
    regfile_mp_wrsel #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WR_PORTS(WR_PORTS)
    ) u_wsel (
      .addr    (ADDR_W'(a)),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hit     (w_hit[a]),
      .data    (w_data[a]),
      .conflict(w_conf[a])
    );
  end

  // A write retires the producer; a new busy_set in the same cycle wins
  // because it represents a freshly issued producer.
  always_comb begin
    busy_next = busy;
    for (int a = 0; a < SIZE; a++) begin
      if (w_hit[a]) busy_next[a] = 1'b0;
      if (busy_set && (a != ZERO_REG) && (busy_addr == ADDR_W'(a)))
        busy_next[a] = 1'b1;
    end
  end

  for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] stored;
    assign ra     = rd_addr[r*ADDR_W +: ADDR_W];
    assign stored = regs[ra];
    // busy_next of address 0 is always 0, so no special case is needed.
    assign rd_busy_next[r] = busy_next[ra];
`ifdef REGFILE_MP_BYPASS_EN
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
    logic              unused_byp_conf;
    regfile_mp_wrsel #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WR_PORTS(WR_PORTS)
    ) u_byp (
      .addr    (ra),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hit     (byp_hit),
      .data    (byp_data),
      .conflict(unused_byp_conf)
    );
    assign rd_data_next[r*DATA_W +: DATA_W] =
      (ra == ADDR_W'(ZERO_REG)) ? '0 : (byp_hit ? byp_data : stored);
`else
    assign rd_data_next[r*DATA_W +: DATA_W] =
      (ra == ADDR_W'(ZERO_REG)) ? '0 : stored;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < SIZE; a++) regs[a] <= '0;
      busy        <= '0;
      rd_data     <= '0;
      rd_busy     <= '0;
      wr_conflict <= 1'b0;
    end else if (en) begin
      for (int a = 0; a < SIZE; a++) begin
        if (w_hit[a]) regs[a] <= w_data[a];
      end
      busy        <= busy_next;
      rd_data     <= rd_data_next;
      rd_busy     <= rd_busy_next;
      wr_conflict <= |w_conf;
    end
  end

endmodule
